// File: rtl/dft_scan_buf.sv
// Scan capture buffer: shifts 32 bits from a DUT scan chain into a word FIFO
// and dumps stored words one at a time, with soft clear / rewind controls.
module dft_scan_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          buf_val_op,
  input  logic          buf_op,
  input  logic          buf_sin_sel,
  input  logic          buf_reset,
  input  logic          sc_sout,
  output logic          buf_op_ack,
  output logic          buf_op_commit,
  output logic          buf_scaning,
  output logic [31:0]   buf_dout,
  output logic [AW:0]   buf_count,
  output logic          buf_ovf
);

  typedef enum logic [2:0] {IDLE, SHIFT, WCOMMIT, RFETCH, RCOMMIT} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   sreg;
  logic [4:0]    bit_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   wr_total;

  logic shift_bit, flush, room, commit_wr, store, drop, pop;

  assign buf_op_ack = (state == IDLE) & buf_val_op & ~buf_reset;
  assign shift_bit  = buf_sin_sel & sc_sout;
  // A rewind during SHIFT keeps whatever bits were already captured.
  assign flush      = buf_reset & buf_op & (state == SHIFT) & (bit_cnt != 5'd0);
  assign room       = buf_count < FULL;
  assign commit_wr  = (state == WCOMMIT) & ~buf_reset;
  assign store      = (commit_wr | flush) & room;
  assign drop       = (commit_wr | flush) & ~room;
  assign pop        = (state == RCOMMIT) & ~buf_reset & (buf_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (buf_reset) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (buf_op_ack) state_nxt = buf_op ? RFETCH : SHIFT;
        SHIFT:   if (bit_cnt == 5'd31) state_nxt = WCOMMIT;
        WCOMMIT: state_nxt = IDLE;
        RFETCH:  state_nxt = RCOMMIT;
        RCOMMIT: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg          <= '0;
      bit_cnt       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wr_total      <= '0;
      buf_count     <= '0;
      buf_ovf       <= 1'b0;
      buf_dout      <= '0;
      buf_op_commit <= 1'b0;
      buf_scaning   <= 1'b0;
    end else begin
      buf_scaning   <= (state_nxt == SHIFT);
      buf_op_commit <= (state_nxt == WCOMMIT) || (state_nxt == RCOMMIT);

      if (buf_op_ack && !buf_op) begin
        sreg    <= '0;
        bit_cnt <= '0;
      end else if (state == SHIFT && !buf_reset) begin
        sreg    <= {shift_bit, sreg[31:1]};
        bit_cnt <= bit_cnt + 5'd1;
      end

      if (state == RFETCH && !buf_reset)
        buf_dout <= (buf_count == '0) ? 32'h0 : mem[rd_ptr];

      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_total != FULL) wr_total <= wr_total + 1'b1;
      end
      if (drop) buf_ovf <= 1'b1;

      if (buf_reset && !buf_op) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        wr_total  <= '0;
        buf_count <= '0;
        buf_ovf   <= 1'b0;
      end else if (buf_reset) begin
        // Rewind: everything written this session becomes readable again.
        rd_ptr    <= '0;
        buf_count <= (store && wr_total != FULL) ? wr_total + 1'b1 : wr_total;
      end else begin
        if (store)    buf_count <= buf_count + 1'b1;
        else if (pop) buf_count <= buf_count - 1'b1;
        if (pop)      rd_ptr    <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= sreg;
  end

endmodule

// File: tb/tb_dft_scan_buf.sv
// Scoreboard bench for dft_scan_buf: stimulus pushes expected commits,
// a negedge monitor pops and compares commit cycle and dumped word.
module tb_dft_scan_buf;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          buf_val_op = 1'b0;
  logic          buf_op = 1'b0;
  logic          buf_sin_sel = 1'b0;
  logic          buf_reset = 1'b0;
  logic          sc_sout = 1'b0;
  logic          buf_op_ack;
  logic          buf_op_commit;
  logic          buf_scaning;
  logic [31:0]   buf_dout;
  logic [AW:0]   buf_count;
  logic          buf_ovf;

  dft_scan_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .buf_val_op    (buf_val_op),
    .buf_op        (buf_op),
    .buf_sin_sel   (buf_sin_sel),
    .buf_reset     (buf_reset),
    .sc_sout       (sc_sout),
    .buf_op_ack    (buf_op_ack),
    .buf_op_commit (buf_op_commit),
    .buf_scaning   (buf_scaning),
    .buf_dout      (buf_dout),
    .buf_count     (buf_count),
    .buf_ovf       (buf_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          is_rd;
    int          at;
    logic [31:0] dout;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every commit pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (reset && buf_op_commit) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL stray_commit: commit at cycle %0d with no operation pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_cycle", 32'(cyc), 32'(e.at));
        if (e.is_rd) chk("rd_dout", buf_dout, e.dout);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // All tasks start and end at 1 time unit after a rising edge, FSM in IDLE.
  task automatic wr_op(input logic [31:0] w, input logic sel);
    int a;
    int sc;
    buf_val_op = 1'b1; buf_op = 1'b0; buf_sin_sel = sel; sc_sout = 1'b0;
    #1 chk("wr_ack", 32'(buf_op_ack), 1);
    a = cyc;
    sb.push_back('{is_rd: 1'b0, at: a + 33, dout: 32'h0});
    sc = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      buf_val_op = 1'b0;
      sc_sout = w[i];
      sc += int'(buf_scaning);
    end
    @(posedge clk); #1;
    sc_sout = 1'b0;
    chk("scan_cycles", 32'(sc), 32);
    chk("scan_off_at_commit", 32'(buf_scaning), 0);
    buf_val_op = 1'b1;
    #1 chk("busy_ack", 32'(buf_op_ack), 0);
    @(posedge clk); #1;
    buf_val_op = 1'b0;
  endtask

  task automatic rd_op(input logic [31:0] exp);
    int a;
    buf_val_op = 1'b1; buf_op = 1'b1;
    #1 chk("rd_ack", 32'(buf_op_ack), 1);
    a = cyc;
    sb.push_back('{is_rd: 1'b1, at: a + 2, dout: exp});
    @(posedge clk); #1;
    buf_val_op = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic soft_reset(input logic op);
    buf_reset = 1'b1; buf_op = op; buf_val_op = 1'b1;
    #1 chk("ack_during_reset", 32'(buf_op_ack), 0);
    @(posedge clk); #1;
    buf_reset = 1'b0; buf_val_op = 1'b0;
  endtask

  // Accepted write with sc_sout=1; returns with k bits already shifted.
  task automatic part_wr(input int k);
    buf_val_op = 1'b1; buf_op = 1'b0; buf_sin_sel = 1'b1; sc_sout = 1'b1;
    #1 chk("part_wr_ack", 32'(buf_op_ack), 1);
    repeat (k + 1) begin
      @(posedge clk); #1;
      buf_val_op = 1'b0;
    end
  endtask

  initial begin
    #2;
    chk("rst_count",   32'(buf_count), 0);
    chk("rst_ovf",     32'(buf_ovf), 0);
    chk("rst_dout",    buf_dout, 32'h0);
    chk("rst_commit",  32'(buf_op_commit), 0);
    chk("rst_scaning", 32'(buf_scaning), 0);
    #21 reset = 1'b1;
    @(posedge clk); #1;

    // Basic write then read
    wr_op(32'hA5A5F00F, 1'b1);
    chk("count_after_wr", 32'(buf_count), 1);
    rd_op(32'hA5A5F00F);
    chk("count_after_rd", 32'(buf_count), 0);

    // Empty read, then confirm rd_ptr did not move
    rd_op(32'h0);
    chk("count_empty_rd", 32'(buf_count), 0);
    wr_op(32'h0BADF00D, 1'b1);
    rd_op(32'h0BADF00D);

    // Constant-zero shift source
    wr_op(32'hFFFFFFFF, 1'b0);
    rd_op(32'h0);

    // Overflow
    soft_reset(1'b0);
    chk("count_new_session", 32'(buf_count), 0);
    for (int i = 0; i <= DEPTH; i++) begin
      wr_op(32'h1000_0000 + 32'(i), 1'b1);
      if (i == DEPTH - 1) begin
        chk("count_full", 32'(buf_count), 32'(DEPTH));
        chk("ovf_not_yet", 32'(buf_ovf), 0);
      end
    end
    chk("count_ovf", 32'(buf_count), 32'(DEPTH));
    chk("ovf_set", 32'(buf_ovf), 1);
    rd_op(32'h1000_0000);
    chk("count_after_ovf_rd", 32'(buf_count), 32'(DEPTH - 1));
    soft_reset(1'b0);
    chk("count_cleared", 32'(buf_count), 0);
    chk("ovf_cleared", 32'(buf_ovf), 0);

    // Rewind with partial flush after 5 bits
    wr_op(32'h1111_1111, 1'b1);
    wr_op(32'h2222_2222, 1'b1);
    wr_op(32'h1234_5678, 1'b1);
    part_wr(5);
    buf_reset = 1'b1; buf_op = 1'b1;
    @(posedge clk); #1;
    buf_reset = 1'b0;
    chk("flush_scan_off", 32'(buf_scaning), 0);
    chk("flush_no_commit", 32'(buf_op_commit), 0);
    chk("count_rewind", 32'(buf_count), 4);
    rd_op(32'h1111_1111);
    rd_op(32'h2222_2222);
    rd_op(32'h1234_5678);
    rd_op(32'hF800_0000);
    chk("count_drained", 32'(buf_count), 0);

    // Asynchronous reset in the middle of a shift
    wr_op(32'hCAFE_0001, 1'b1);
    chk("count_before_async", 32'(buf_count), 1);
    part_wr(10);
    chk("scaning_mid_shift", 32'(buf_scaning), 1);
    reset = 1'b0;
    #1;
    chk("async_scaning", 32'(buf_scaning), 0);
    chk("async_commit",  32'(buf_op_commit), 0);
    chk("async_count",   32'(buf_count), 0);
    chk("async_dout",    buf_dout, 32'h0);
    chk("async_ovf",     32'(buf_ovf), 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    soft_reset(1'b1);
    chk("no_word_after_async", 32'(buf_count), 0);
    rd_op(32'h0);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
